step_position_tracker: RTL

- Feedback path from one stepper axis back to the processor.
- Counts step pulses, using the dir level to decide up or down, into a signed absolute position.
- Compares that position against a target that the processor arms.
- On arrival, limit hit or stall, hands a status word back for write into the register file over a valid/ready write-back port. It is the return leg of the step_x/y_dir/speed command registers.

---
 rtl/tracker_pkg.sv | 27 ++
 rtl/step_edge_counter.sv | 65 ++++++
 rtl/step_position_tracker.sv | 135 +++++++++++++
 3 files changed

// File: rtl/tracker_pkg.sv
// ============================================================================
//  tracker_pkg
//  Shared encodings for the step position tracker and its status slot.
//  Rev 1.0
// ============================================================================
`default_nettype none

package tracker_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TRACK  = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CODE_DONE  = 2'b01,
        CODE_LIMIT = 2'b10,
        CODE_STALL = 2'b11
    } status_code_t;

    // Register-file slot that receives the tracker status word.
    localparam logic [4:0] c_WB_REG_DEFAULT = 5'd27;

endpackage

`default_nettype wire

// File: rtl/step_edge_counter.sv
// ============================================================================
//  step_edge_counter
//  Rising-edge step counter with direction, zeroing and saturating soft limits.
//  Rev 1.0
// ============================================================================
`default_nettype none

module step_edge_counter #(
    parameter int                       POS_W   = 32,
    parameter logic signed [POS_W-1:0]  MIN_POS = -32'sd100000,
    parameter logic signed [POS_W-1:0]  MAX_POS = 32'sd100000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                step_in,
    input  logic                dir_in,
    input  logic                zero_pos,
    input  logic                clr_limit,
    output logic                step_edge,
    output logic [POS_W-1:0]    position,
    output logic                limit_hit
);

    localparam logic signed [POS_W:0] c_MAX_EXT = {MAX_POS[POS_W-1], MAX_POS};
    localparam logic signed [POS_W:0] c_MIN_EXT = {MIN_POS[POS_W-1], MIN_POS};

    logic                       r_step_q;
    logic signed [POS_W-1:0]    r_position;
    logic                       r_limit_hit;
    logic signed [POS_W:0]      w_sum;
    logic                       w_out_of_range;

    assign step_edge = step_in & ~r_step_q;

    // One extra bit keeps the limit compare free of wrap-around.
    assign w_sum = {r_position[POS_W-1], r_position}
                 + (dir_in ? (POS_W+1)'(1) : {(POS_W+1){1'b1}});
    assign w_out_of_range = (w_sum > c_MAX_EXT) || (w_sum < c_MIN_EXT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_step_q    <= 1'b0;
            r_position  <= '0;
            r_limit_hit <= 1'b0;
        end else begin
            r_step_q <= step_in;
            if (clr_limit)
                r_limit_hit <= 1'b0;
            if (zero_pos) begin
                r_position <= '0;
            end else if (step_edge) begin
                if (w_out_of_range)
                    r_limit_hit <= 1'b1;
                else
                    r_position <= w_sum[POS_W-1:0];
            end
        end
    end

    assign position  = r_position;
    assign limit_hit = r_limit_hit;

endmodule

`default_nettype wire

// File: rtl/step_position_tracker.sv
// ============================================================================
//  step_position_tracker
//  Tracks axis position against an armed target and writes back a status word.
//  Rev 1.0
// ============================================================================
`default_nettype none

module step_position_tracker
    import tracker_pkg::*;
#(
    parameter int                       POS_W        = 32,
    parameter logic signed [POS_W-1:0]  MIN_POS      = -32'sd100000,
    parameter logic signed [POS_W-1:0]  MAX_POS      = 32'sd100000,
    parameter int                       STALL_CYCLES = 200000,
    parameter logic [4:0]               WB_REG       = c_WB_REG_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                step_in,
    input  logic                dir_in,
    input  logic                zero_pos,
    input  logic                cmd_valid,
    input  logic [POS_W-1:0]    cmd_target,
    output logic                cmd_ready,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [4:0]          wb_reg,
    output logic [POS_W-1:0]    wb_data,
    output logic [POS_W-1:0]    position,
    output logic                busy,
    output logic                limit_hit
);

    localparam int                      c_STALL_W    = (STALL_CYCLES > 2) ? $clog2(STALL_CYCLES) : 1;
    localparam logic [c_STALL_W-1:0]    c_STALL_LAST = c_STALL_W'(STALL_CYCLES - 1);

    state_t                 r_state;
    logic [POS_W-1:0]       r_target;
    logic [c_STALL_W-1:0]   r_stall_cnt;
    logic                   r_cmd_ready;
    logic                   r_wb_valid;
    logic                   r_busy;
    logic [POS_W-1:0]       r_wb_data;
    logic                   w_accept;
    logic                   w_step_edge;
    logic [POS_W-1:0]       w_position;
    logic                   w_limit_hit;

    assign w_accept = (r_state == S_IDLE) && cmd_valid && r_cmd_ready;

    step_edge_counter #(
        .POS_W   (POS_W),
        .MIN_POS (MIN_POS),
        .MAX_POS (MAX_POS)
    ) u_counter (
        .clock     (clock),
        .reset     (reset),
        .step_in   (step_in),
        .dir_in    (dir_in),
        .zero_pos  (zero_pos),
        .clr_limit (w_accept),
        .step_edge (w_step_edge),
        .position  (w_position),
        .limit_hit (w_limit_hit)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_target    <= '0;
            r_stall_cnt <= '0;
            r_cmd_ready <= 1'b1;
            r_wb_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_wb_data   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_target    <= cmd_target;
                        r_stall_cnt <= '0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_TRACK;
                    end
                end
                S_TRACK: begin
                    // Exit checks use the registered position, so DONE lands one cycle after the edge.
                    if (w_position == r_target) begin
                        r_wb_data  <= {CODE_DONE, w_position[POS_W-3:0]};
                        r_wb_valid <= 1'b1;
                        r_state    <= S_REPORT;
                    end else if (w_limit_hit) begin
                        r_wb_data  <= {CODE_LIMIT, w_position[POS_W-3:0]};
                        r_wb_valid <= 1'b1;
                        r_state    <= S_REPORT;
                    end else if (r_stall_cnt == c_STALL_LAST) begin
                        r_wb_data  <= {CODE_STALL, w_position[POS_W-3:0]};
                        r_wb_valid <= 1'b1;
                        r_state    <= S_REPORT;
                    end else if (w_step_edge) begin
                        r_stall_cnt <= '0;
                    end else begin
                        r_stall_cnt <= r_stall_cnt + 1'b1;
                    end
                end
                S_REPORT: begin
                    if (r_wb_valid && wb_ready) begin
                        r_wb_valid  <= 1'b0;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_wb_valid  <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign wb_valid  = r_wb_valid;
    assign wb_data   = r_wb_data;
    assign wb_reg    = WB_REG;
    assign busy      = r_busy;
    assign position  = w_position;
    assign limit_hit = w_limit_hit;

endmodule

`default_nettype wire
